// File: rtl/fc_act_packer.sv
// fc_act_packer: ReLU, 4-per-word byte packing into an output FIFO, and per-vector argmax.
module fc_act_packer #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              relu_en_i,
  input  logic              clr_i,
  input  logic              fc_valid_i,
  input  logic              last_i,
  input  logic signed [7:0] fc_result_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [31:0]       out_data_o,
  output logic              out_last_o,
  output logic [2:0]        out_bytes_o,
  output logic              done_o,
  output logic [6:0]        argmax_o,
  output logic [7:0]        max_o,
  output logic              overflow_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic {S_IDLE, S_VEC} state_t;
  state_t state_q, state_d;
  logic relu_q, done_q, ovf_q;
  logic [1:0] bcnt_q;
  logic [31:0] word_q;
  logic [6:0] idx_q, run_idx_q, argmax_q;
  logic signed [7:0] run_max_q, max_q;
  logic [35:0] mem [FIFO_DEPTH];
  logic [AW:0] wptr_q, rptr_q;
  logic first, relu, push, upd, empty, full, pop, wr;
  logic [7:0] act;
  logic signed [7:0] nmax;
  logic [6:0] idx, nidx;
  logic [31:0] wdata;
  logic [35:0] head;
  always_comb begin
    state_d = state_q;
    if (fc_valid_i) state_d = last_i ? S_IDLE : S_VEC;
  end
  always_comb begin
    first = state_q == S_IDLE;
    relu  = first ? relu_en_i : relu_q;
    act   = (relu && fc_result_i[7]) ? 8'h00 : fc_result_i;
    idx   = first ? 7'd0 : idx_q;
    wdata = word_q | (32'(act) << {bcnt_q, 3'b000});
    push  = fc_valid_i && (bcnt_q == 2'd3 || last_i);
    upd   = first || (fc_result_i > run_max_q);
    nmax  = upd ? fc_result_i : run_max_q;
    nidx  = upd ? idx : run_idx_q;
    empty = wptr_q == rptr_q;
    full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    pop   = !empty && out_ready_i;
    wr    = push && (!full || pop);
    head  = mem[rptr_q[AW-1:0]];
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      relu_q    <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      bcnt_q    <= '0;
      word_q    <= '0;
      idx_q     <= '0;
      run_idx_q <= '0;
      argmax_q  <= '0;
      run_max_q <= 8'sh80;
      max_q     <= 8'sh80;
      wptr_q    <= '0;
      rptr_q    <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= fc_valid_i && last_i;
      if (fc_valid_i) begin
        relu_q    <= relu;
        idx_q     <= idx + 7'd1;
        run_max_q <= nmax;
        run_idx_q <= nidx;
        bcnt_q    <= push ? 2'd0 : bcnt_q + 2'd1;
        word_q    <= push ? 32'd0 : wdata;
        if (last_i) begin
          max_q    <= nmax;
          argmax_q <= nidx;
        end
      end
      wptr_q <= wptr_q + (AW+1)'(wr);
      rptr_q <= rptr_q + (AW+1)'(pop);
      // A fresh drop beats a simultaneous clear
      ovf_q  <= (push && full && !pop) || (ovf_q && !clr_i);
    end
  end
  always_ff @(posedge clk) begin
    if (wr) mem[wptr_q[AW-1:0]] <= {wdata, last_i, {1'b0, bcnt_q} + 3'd1};
  end
  assign out_valid_o = !empty;
  assign out_data_o  = head[35:4];
  assign out_last_o  = !empty && head[3];
  assign out_bytes_o = empty ? 3'd0 : head[2:0];
  assign done_o      = done_q;
  assign argmax_o    = argmax_q;
  assign max_o       = max_q;
  assign overflow_o  = ovf_q;
endmodule

// File: tb/tb_fc_act_packer.sv
// tb_fc_act_packer: directed stimulus with queue scoreboard for packed words and done results.
module tb_fc_act_packer;
  logic clk = 1'b0, rst_n = 1'b0, relu_en_i = 1'b0, clr_i = 1'b0;
  logic fc_valid_i = 1'b0, last_i = 1'b0, out_ready_i = 1'b1;
  logic signed [7:0] fc_result_i = '0;
  logic out_valid_o, out_last_o, done_o, overflow_o;
  logic [31:0] out_data_o;
  logic [2:0] out_bytes_o;
  logic [6:0] argmax_o;
  logic [7:0] max_o;
  int tests = 0, fails = 0;
  logic [35:0] exp_w [$];
  logic [14:0] exp_d [$];

  fc_act_packer #(.FIFO_DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .relu_en_i(relu_en_i), .clr_i(clr_i),
    .fc_valid_i(fc_valid_i), .last_i(last_i), .fc_result_i(fc_result_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
    .out_last_o(out_last_o), .out_bytes_o(out_bytes_o), .done_o(done_o),
    .argmax_o(argmax_o), .max_o(max_o), .overflow_o(overflow_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [35:0] got, input logic [35:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got %h expected %h", name, got, want);
    end
  endtask

  function automatic logic [31:0] w4(input int k);
    return {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
  endfunction

  task automatic ew(input logic [31:0] d, input logic l, input logic [2:0] b);
    exp_w.push_back({d, l, b});
  endtask

  task automatic ed(input logic [6:0] a, input logic [7:0] m);
    exp_d.push_back({a, m});
  endtask

  task automatic drive(input logic [7:0] v, input logic l);
    fc_valid_i = 1'b1;
    fc_result_i = v;
    last_i = l;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    fc_valid_i = 1'b0;
    last_i = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_w.size() != 0 || exp_d.size() != 0) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk({name, "_drained"}, 36'(exp_w.size() + exp_d.size()), 36'd0);
    exp_w.delete();
    exp_d.delete();
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid_o && out_ready_i) begin
        if (exp_w.size() == 0) chk("unexpected_word", {out_data_o, out_last_o, out_bytes_o}, 36'hx);
        else chk("word", {out_data_o, out_last_o, out_bytes_o}, exp_w.pop_front());
      end
      if (done_o) begin
        if (exp_d.size() == 0) chk("unexpected_done", 36'({argmax_o, max_o}), 36'hx);
        else chk("done_argmax_max", 36'({argmax_o, max_o}), 36'(exp_d.pop_front()));
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", 36'({out_valid_o, out_last_o, out_bytes_o, done_o, argmax_o, max_o, overflow_o}),
        36'({1'b0, 1'b0, 3'd0, 1'b0, 7'd0, 8'h80, 1'b0}));
    rst_n = 1'b1;
    @(posedge clk); #1;

    relu_en_i = 1'b1;
    ew(32'h007F0500, 1'b0, 3'd4); ew(32'h00020100, 1'b1, 3'd4); ed(7'd2, 8'h7F);
    drive(8'hFD, 0); drive(8'h05, 0); drive(8'h7F, 0); drive(8'h80, 0);
    drive(8'h00, 0); drive(8'h01, 0); drive(8'h02, 0); drive(8'hFF, 1);
    idle();
    wait_drain("relu8");

    relu_en_i = 1'b0;
    ew(32'h40302010, 1'b0, 3'd4); ew(32'h00000050, 1'b1, 3'd1); ed(7'd4, 8'h50);
    drive(8'h10, 0); drive(8'h20, 0); drive(8'h30, 0); drive(8'h40, 0); drive(8'h50, 1);
    idle();
    wait_drain("norelu5");

    relu_en_i = 1'b1;
    ew(32'h00000000, 1'b1, 3'd3); ed(7'd1, 8'hFE);
    ew(32'h00050505, 1'b1, 3'd3); ed(7'd0, 8'h05);
    drive(8'hFB, 0); drive(8'hFE, 0); drive(8'hF7, 1);
    drive(8'h05, 0); drive(8'h05, 0); drive(8'h05, 1);
    idle();
    wait_drain("neg_and_tie");

    relu_en_i = 1'b0;
    out_ready_i = 1'b0;
    for (int k = 0; k < 8; k++) ew(w4(k), 1'b0, 3'd4);
    for (int i = 0; i < 36; i++) drive(8'(i), 0);
    idle();
    chk("overflow_set", 36'(overflow_o), 36'd1);
    out_ready_i = 1'b1;
    wait_drain("overflow_drain");
    clr_i = 1'b1;
    @(posedge clk); #1;
    clr_i = 1'b0;
    chk("overflow_cleared", 36'(overflow_o), 36'd0);
    ew(32'h00000024, 1'b1, 3'd1); ed(7'd36, 8'h24);
    drive(8'h24, 1);
    idle();
    wait_drain("close_vec");

    out_ready_i = 1'b0;
    for (int k = 0; k < 9; k++) ew(w4(k), k == 8, 3'd4);
    ed(7'd35, 8'h23);
    for (int i = 0; i < 36; i++) begin
      if (i == 35) out_ready_i = 1'b1;
      drive(8'(i), i == 35);
    end
    idle();
    chk("full_push_pop_no_ovf", 36'(overflow_o), 36'd0);
    wait_drain("full_push_pop");

    drive(8'h09, 0); drive(8'h09, 0);
    idle();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("midvec_reset", 36'({out_valid_o, done_o, argmax_o, max_o, overflow_o}),
        36'({1'b0, 1'b0, 7'd0, 8'h80, 1'b0}));
    ew(32'h04030201, 1'b1, 3'd4); ed(7'd3, 8'h04);
    drive(8'h01, 0); drive(8'h02, 0); drive(8'h03, 0); drive(8'h04, 1);
    idle();
    wait_drain("after_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
